// File: rtl/sdram_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_write_buffer_pkg
// Brief    : Bank-state encodings and 36-bit buffer word layout.
// Revision : 1.0
// ============================================================================
package sdram_write_buffer_pkg;

    typedef logic [1:0] buf_state_t;

    localparam buf_state_t BUF_EMPTY   = 2'd0;
    localparam buf_state_t BUF_FILLING = 2'd1;
    localparam buf_state_t BUF_READY   = 2'd2;
    localparam buf_state_t BUF_READING = 2'd3;

    localparam int c_data_w   = 32;
    localparam int c_mask_w   = 4;
    localparam int c_word_w   = 36;
    localparam int c_mask_msb = 35;
    localparam int c_mask_lsb = 32;
    localparam int c_data_msb = 31;
    localparam int c_data_lsb = 0;
    localparam int c_size_w   = 24;

    function automatic logic [c_word_w-1:0] pack_word(input logic [c_mask_w-1:0] mask,
                                                      input logic [c_data_w-1:0] data);
        logic [c_word_w-1:0] w;
        w = '0;
        w[c_mask_msb:c_mask_lsb] = mask;
        w[c_data_msb:c_data_lsb] = data;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_write_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_write_buffer_if
// Brief    : Application write port plus FIFO-consumer handshake to the engine.
// Revision : 1.0
// ============================================================================
interface sdram_write_buffer_if;
    import sdram_write_buffer_pkg::*;

    logic                wr_ready;
    logic                wr_stb;
    logic [c_data_w-1:0] wr_data;
    logic [c_mask_w-1:0] wr_mask;
    logic                flush;
    logic                wr_overflow;
    logic [c_word_w-1:0] fifo_data;
    logic                fifo_read;
    logic                fifo_ready;
    logic                fifo_activate;
    logic [c_size_w-1:0] fifo_size;
    logic                fifo_inactive;

    modport slave (
        output wr_ready, wr_overflow, fifo_data, fifo_ready, fifo_size, fifo_inactive,
        input  wr_stb, wr_data, wr_mask, flush, fifo_read, fifo_activate
    );

    modport master (
        input  wr_ready, wr_overflow, fifo_data, fifo_ready, fifo_size, fifo_inactive,
        output wr_stb, wr_data, wr_mask, flush, fifo_read, fifo_activate
    );
endinterface
`default_nettype wire

// File: rtl/sdram_wbuf_bank.sv
`default_nettype none
// ============================================================================
// Module   : sdram_wbuf_bank
// Brief    : Simple dual-port synchronous RAM, one write and one read port.
// Revision : 1.0
// ============================================================================
module sdram_wbuf_bank #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 36
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   i_we,
    input  wire  [ADDR_WIDTH-1:0] i_waddr,
    input  wire  [DATA_WIDTH-1:0] i_wdata,
    input  wire                   i_re,
    input  wire  [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the output register resets; the array stays plain RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sdram_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_write_buffer
// Brief    : Ping-pong write buffer: the application fills one bank while the
//            SDRAM write engine drains the other.
// Revision : 1.0
// ============================================================================
module sdram_write_buffer
    import sdram_write_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input wire                  clk,
    input wire                  rst,
    sdram_write_buffer_if.slave bus
);

    localparam int unsigned         c_depth = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_last  = (ADDR_WIDTH+1)'(c_depth - 1);

    buf_state_t          r_state [2];
    buf_state_t          w_state_nxt [2];
    logic [ADDR_WIDTH:0] r_count [2];
    logic [ADDR_WIDTH:0] w_count_nxt [2];
    logic                r_oldest, w_oldest_nxt;
    logic                r_rd_bank, w_rd_bank_nxt;
    logic [ADDR_WIDTH:0] r_rd_ptr, w_rd_ptr_nxt;
    logic                r_act_d;
    logic                r_overflow;
    logic                r_fifo_ready, w_fifo_ready_nxt;
    logic [c_size_w-1:0] r_fifo_size, w_fifo_size_nxt;
    logic                r_inactive, w_inactive_nxt;

    logic                w_fill;
    logic                w_wr_ready;
    logic                w_wr_accept;
    logic                w_commit;
    logic                w_any_ready;
    logic                w_oldest;
    logic                w_reading;
    logic                w_act_rise;
    logic                w_act_fall;
    logic                w_pop;
    logic [ADDR_WIDTH:0] w_rd_addr;
    logic [c_word_w-1:0] w_bank_rdata [2];

    // ---------------------------------------------------------------- outputs
    always_comb begin
        // An active FILLING bank keeps the fill role; otherwise the first EMPTY one.
        w_fill      = (r_state[0] != BUF_FILLING) &&
                      ((r_state[1] == BUF_FILLING) || (r_state[0] != BUF_EMPTY));
        w_wr_ready  = (r_state[0] == BUF_EMPTY) || (r_state[0] == BUF_FILLING) ||
                      (r_state[1] == BUF_EMPTY) || (r_state[1] == BUF_FILLING);
        w_wr_accept = bus.wr_stb && w_wr_ready;
        w_commit    = w_wr_accept ? ((r_count[w_fill] == c_last) || bus.flush)
                                  : (bus.flush && (r_state[w_fill] == BUF_FILLING));
        w_any_ready = (r_state[0] == BUF_READY) || (r_state[1] == BUF_READY);
        w_oldest    = ((r_state[0] == BUF_READY) && (r_state[1] == BUF_READY)) ? r_oldest
                                                                              : (r_state[1] == BUF_READY);
        w_reading   = (r_state[r_rd_bank] == BUF_READING);
        w_act_rise  = bus.fifo_activate && !r_act_d;
        w_act_fall  = !bus.fifo_activate && r_act_d;
        w_pop       = bus.fifo_read && w_reading && (r_rd_ptr != r_count[r_rd_bank]);
        // Look one word ahead on a pop so back-to-back reads stream every cycle.
        w_rd_addr   = r_rd_ptr + (ADDR_WIDTH+1)'(w_pop);
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_oldest_nxt  = r_oldest;
        w_rd_bank_nxt = r_rd_bank;
        w_rd_ptr_nxt  = r_rd_ptr;

        if (w_wr_accept) begin
            w_count_nxt[w_fill] = r_count[w_fill] + 1'b1;
            w_state_nxt[w_fill] = w_commit ? BUF_READY : BUF_FILLING;
        end else if (w_commit) begin
            w_state_nxt[w_fill] = BUF_READY;
        end
        if (w_commit) begin
            w_oldest_nxt = (r_state[!w_fill] == BUF_READY) ? !w_fill : w_fill;
        end

        if (w_act_rise && r_fifo_ready) begin
            w_state_nxt[w_oldest] = BUF_READING;
            w_rd_bank_nxt         = w_oldest;
            w_rd_ptr_nxt          = '0;
        end else if (w_pop) begin
            w_rd_ptr_nxt = w_rd_addr;
        end

        // Release discards any unread words.
        if (w_act_fall && w_reading) begin
            w_state_nxt[r_rd_bank] = BUF_EMPTY;
            w_count_nxt[r_rd_bank] = '0;
        end

        w_fifo_ready_nxt = w_any_ready && !w_reading && !bus.fifo_activate;
        if (w_fifo_ready_nxt) begin
            w_fifo_size_nxt = c_size_w'(r_count[w_oldest]);
        end else if (w_reading) begin
            w_fifo_size_nxt = c_size_w'(r_count[r_rd_bank]);
        end else begin
            w_fifo_size_nxt = '0;
        end
        w_inactive_nxt = (r_state[0] == BUF_EMPTY) && (r_state[1] == BUF_EMPTY) &&
                         !bus.fifo_activate;
    end

    // ---------------------------------------------------------- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= '{BUF_EMPTY, BUF_EMPTY};
            r_count      <= '{'0, '0};
            r_oldest     <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_rd_ptr     <= '0;
            r_act_d      <= 1'b0;
            r_overflow   <= 1'b0;
            r_fifo_ready <= 1'b0;
            r_fifo_size  <= '0;
            r_inactive   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_oldest     <= w_oldest_nxt;
            r_rd_bank    <= w_rd_bank_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_act_d      <= bus.fifo_activate;
            r_overflow   <= r_overflow || (bus.wr_stb && !w_wr_ready);
            r_fifo_ready <= w_fifo_ready_nxt;
            r_fifo_size  <= w_fifo_size_nxt;
            r_inactive   <= w_inactive_nxt;
        end
    end

    // ------------------------------------------------------------------ banks
    for (genvar b = 0; b < 2; b++) begin : g_bank
        sdram_wbuf_bank #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (c_word_w)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_wr_accept && (w_fill == 1'(b))),
            .i_waddr (r_count[w_fill][ADDR_WIDTH-1:0]),
            .i_wdata (pack_word(bus.wr_mask, bus.wr_data)),
            .i_re    (w_reading && (r_rd_bank == 1'(b)) && (w_rd_addr < r_count[b])),
            .i_raddr (w_rd_addr[ADDR_WIDTH-1:0]),
            .o_rdata (w_bank_rdata[b])
        );
    end

    assign bus.wr_ready      = w_wr_ready;
    assign bus.wr_overflow   = r_overflow;
    assign bus.fifo_data     = w_bank_rdata[r_rd_bank];
    assign bus.fifo_ready    = r_fifo_ready;
    assign bus.fifo_size     = r_fifo_size;
    assign bus.fifo_inactive = r_inactive;

endmodule
`default_nettype wire

// File: doc/sdram_write_buffer.md
Name: sdram_write_buffer

Overview:
Single-clock ping-pong write buffer that sits directly upstream of the SDRAM write engine. It collects 32-bit application write words with byte masks into two alternating banks. Each filled or flushed bank is handed to the write engine through the FIFO consumer handshake (ready/activate/size/read/inactive). While the engine drains one bank, the application fills the other.

Parameters:
ADDR_WIDTH, 8, log2 of words per bank (DEPTH = 2**ADDR_WIDTH = 256 by default; must be 1..23)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wr_ready  out  1  a bank is available to accept words
wr_stb  in  1  write one word this cycle
wr_data  in  32  write word; [31:16] upper halfword, [15:0] lower halfword
wr_mask  in  4  DQM bits; 1 = byte not written; [3:2] upper halfword, [1:0] lower halfword
flush  in  1  commit the partially filled bank now
wr_overflow  out  1  sticky: wr_stb seen while wr_ready low
fifo_data  out  36  {mask[3:0], data[31:0]} at the read pointer of the active bank
fifo_read  in  1  pop one word from the active bank
fifo_ready  out  1  a committed bank is waiting and no bank is active
fifo_activate  in  1  consumer owns a bank while high
fifo_size  out  24  word count of the bank offered or active, zero-extended
fifo_inactive  out  1  both banks EMPTY and fifo_activate low

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. All registers clear on rst assertion, irrespective of clk.
- Reset values: wr_ready=1, wr_overflow=0, fifo_data=0, fifo_ready=0, fifo_size=0, fifo_inactive=1. Both banks are EMPTY, pointers and counts are 0, and the fill bank is bank 0.
- Each bank has a 2-bit state: EMPTY, FILLING, READY, READING. A 1-bit commit-order register records which READY bank is oldest.
- Fill bank selection: first EMPTY bank, bank 0 first. The selected bank becomes FILLING on its first wr_stb.
- wr_ready = 1 when a bank is FILLING with count < DEPTH, or when a bank is EMPTY.
- wr_stb with wr_ready: {wr_mask, wr_data} is written at the fill count, and the count increments.
- Commit: the fill bank goes FILLING->READY when its count reaches DEPTH, or when flush is high with count > 0. This happens in the same cycle as the word that fills it.
- flush with count 0 is ignored.
- flush together with wr_stb: the word is written first, and the bank commits with count+1.
- wr_stb while wr_ready is low: the word is dropped and wr_overflow is set. wr_overflow clears only on rst.
- fifo_ready (registered) = 1 when a READY bank exists, no bank is READING, and fifo_activate is low.
- fifo_size shows the count of the oldest READY bank while fifo_ready is high, and the active bank count while it is READING.
- fifo_activate rising while fifo_ready is high: the oldest READY bank becomes READING, its read pointer goes to 0, and fifo_ready drops the next cycle. fifo_activate rising while fifo_ready is low is ignored.
- fifo_data is first-word-fall-through. It presents word 0 within 2 cycles of activate.
- fifo_read advances the read pointer, and fifo_data shows the new word on the next cycle.
- fifo_read at pointer == count is ignored: the pointer saturates and fifo_data holds.
- fifo_activate falling: the READING bank goes to EMPTY (count 0), whether or not it was fully read.
- Simultaneous events are independent:
  - a commit on one bank and a release on the other in the same cycle both take effect;
  - a released bank can be selected for filling on the next cycle.
- RAM read latency is 1 cycle. The RAM is synchronous, with one write port and one read port per bank.

Decomposition:
- Shared include (alongside sdram_include.v): bank-state encodings BUF_EMPTY/BUF_FILLING/BUF_READY/BUF_READING, and the 36-bit word field offsets (mask 35:32, data 31:0).
- One sub-module: sdram_wbuf_bank, a simple dual-port synchronous RAM with width 36 and depth 2**ADDR_WIDTH. It is instantiated twice.

Test Plan:
- Reset check: assert rst mid-fill after 10 words -> all outputs return to reset values asynchronously; bank 0 refills from count 0.
- Single partial bank: write 3 words 0x11112222/0x33334444/0x55556666 with mask 0, then flush -> fifo_ready=1 and fifo_size=3. Activate and pop 3 times -> fifo_data sequence 0x0_11112222, 0x0_33334444, 0x0_55556666. Drop activate -> fifo_inactive=1.
- Full-bank auto-commit and ping-pong: write 256 words (value = index) without flush -> bank 0 is READY at word 256; wr_ready stays 1. Words 256..300 land in bank 1; bank 0 drains in order 0..255 while bank 1 fills.
- Order and backpressure: fill both banks (512 words) with the consumer idle -> wr_ready=0. The 513th wr_stb sets wr_overflow=1 and is dropped. The consumer gets bank 0 (size 256) before bank 1.
- Mask and edge cases:
  - write 0xDEADBEEF with mask 4'b1001 and flush -> fifo_data=36'h9_DEADBEEF;
  - a fifo_read beyond size 1 holds the value;
  - flush with an empty bank -> fifo_ready stays 0.
- Simultaneous events: flush together with wr_stb, in the same cycle that the consumer releases the other bank -> committed size includes that word; the released bank is EMPTY and fillable the next cycle.
